// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM transmitter and receiver.
package tdm_pkg;

  typedef enum logic {HUNT, RUN} tdm_state_e;

  // Slot index width; a single-slot frame still needs one bit to hold 0.
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-NUM_CH slot counter. Priority: clr, then load1, then inc.
// wrap is high while the counter sits on the last slot of the frame.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        inc,
  input  logic                        load1,
  input  logic                        clr,
  output logic [slot_w(NUM_CH)-1:0]   cnt,
  output logic                        wrap
);

  localparam int SW = slot_w(NUM_CH);
  localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);

  assign wrap = (cnt == LAST);

  // Slot register; incrementing from the last slot folds back to 0 so the
  // value never reaches NUM_CH.
  always_ff @(posedge clk) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (load1)  cnt <= SW'(1);
    else if (inc)    cnt <= wrap ? '0 : cnt + SW'(1);
  end

endmodule

// File: rtl/tdm_demux.sv
// Receive side of the TDM link: realigns on SOF, collects one sample per
// slot into a capture buffer and publishes whole frames with a 1-cycle strobe.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic                        in_sof,
  input  logic [WIDTH-1:0]            in_data,
  output logic [NUM_CH*WIDTH-1:0]     out_data,
  output logic                        out_valid,
  output logic [slot_w(NUM_CH)-1:0]   slot_idx,
  output logic                        locked,
  output logic                        sync_err
);

  localparam int SW = slot_w(NUM_CH);

  tdm_state_e state, state_n;

  logic                          cnt_inc, cnt_load1, cnt_clr, cnt_wrap;
  logic                          cap_we, err_n, publish;
  logic [SW-1:0]                 cap_idx;
  logic [NUM_CH-1:0][WIDTH-1:0]  cap, frame_n, out_q;

  tdm_slot_counter #(.NUM_CH(NUM_CH)) u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .cnt   (slot_idx),
    .wrap  (cnt_wrap)
  );

  assign locked   = (state == RUN);
  assign out_data = out_q;

  // Framing state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_n;
  end

  // Next state, slot counter controls, capture write and publish decisions.
  always_comb begin
    state_n   = state;
    cnt_inc   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_clr   = 1'b0;
    cap_we    = 1'b0;
    cap_idx   = slot_idx;
    err_n     = 1'b0;
    publish   = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (in_sof) begin
            cap_we    = 1'b1;
            cap_idx   = '0;
            cnt_load1 = 1'b1;
            state_n   = RUN;
          end
        end
        RUN: begin
          if (in_sof) begin
            // SOF restarts the frame; if a frame was in flight it is dropped.
            cap_we    = 1'b1;
            cap_idx   = '0;
            cnt_load1 = 1'b1;
            err_n     = (slot_idx != '0);
          end else if (slot_idx == '0) begin
            // Expected a frame start and did not get one: lose lock.
            err_n   = 1'b1;
            cnt_clr = 1'b1;
            state_n = HUNT;
          end else begin
            cap_we = 1'b1;
            if (cnt_wrap) begin
              publish = 1'b1;
              cnt_clr = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // The last sample bypasses the capture buffer so the frame is published
  // on the same edge that accepts it.
  always_comb begin
    frame_n           = cap;
    frame_n[NUM_CH-1] = in_data;
  end

  // Capture buffer, output frame register and the one-cycle strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap       <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= publish;
      sync_err  <= err_n;
      if (cap_we)  cap[cap_idx] <= in_data;
      if (publish) out_q        <= frame_n;
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed vector table (2x8), a back-to-back run on a
// 3x1 instance, and random traffic on both against a frame-level model.
module tb_tdm_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2-channel, 8-bit instance
  logic        rst2, v2, sof2;
  logic [7:0]  d2;
  logic [15:0] od2;
  logic        ov2, lk2, er2;
  logic [0:0]  si2;

  // 3-channel, 1-bit instance
  logic        rst3, v3, sof3;
  logic [0:0]  d3;
  logic [2:0]  od3;
  logic        ov3, lk3, er3;
  logic [1:0]  si3;

  tdm_demux #(.NUM_CH(2), .WIDTH(8)) dut2 (
    .clk(clk), .rst_n(rst2), .in_valid(v2), .in_sof(sof2), .in_data(d2),
    .out_data(od2), .out_valid(ov2), .slot_idx(si2), .locked(lk2), .sync_err(er2));

  tdm_demux #(.NUM_CH(3), .WIDTH(1)) dut3 (
    .clk(clk), .rst_n(rst3), .in_valid(v3), .in_sof(sof3), .in_data(d3),
    .out_data(od3), .out_valid(ov3), .slot_idx(si3), .locked(lk3), .sync_err(er3));

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- directed vectors (2x8) ----------------
  typedef struct {
    logic        rst_n, v, sof;
    logic [7:0]  d;
    logic        ov;
    logic [15:0] od;
    logic        lk;
    logic        si;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, v, s, input logic [7:0] d,
                              input logic ov, input logic [15:0] od,
                              input logic lk, si, er);
    vec_t x;
    x.rst_n = r; x.v = v; x.sof = s; x.d = d;
    x.ov = ov; x.od = od; x.lk = lk; x.si = si; x.er = er;
    return x;
  endfunction

  // ---------------- frame-level reference model ----------------
  // A frame is an array of n samples; it becomes visible only when complete.
  typedef struct {
    bit run;
    int pos;
    int cap[4];
    int out[4];
    bit ov, err;
  } model_t;

  function automatic model_t mstep(input model_t m, input int n, input bit rst,
                                   input bit v, input bit sof, input int d);
    model_t r = m;
    if (rst) begin
      r.run = 0; r.pos = 0; r.ov = 0; r.err = 0;
      for (int k = 0; k < 4; k++) begin r.cap[k] = 0; r.out[k] = 0; end
      return r;
    end
    r.ov = 0; r.err = 0;
    if (!v) return r;
    if (sof) begin
      if (r.run && r.pos != 0) r.err = 1;
      r.run = 1; r.cap[0] = d; r.pos = 1;
    end else if (r.run) begin
      if (r.pos == 0) begin
        r.err = 1; r.run = 0;
      end else begin
        r.cap[r.pos] = d;
        r.pos++;
        if (r.pos == n) begin
          for (int k = 0; k < n; k++) r.out[k] = r.cap[k];
          r.ov = 1; r.pos = 0;
        end
      end
    end
    return r;
  endfunction

  model_t m2, m3;
  bit     fr[3];

  initial begin
    rst2 = 0; v2 = 0; sof2 = 0; d2 = '0;
    rst3 = 0; v3 = 0; sof3 = 0; d3 = '0;

    // 1: basic frame
    tbl.push_back(mk(0,0,0,8'h00, 0,16'h0000,0,0,0));
    tbl.push_back(mk(1,1,1,8'hA5, 0,16'h0000,1,1,0));
    tbl.push_back(mk(1,1,0,8'h3C, 1,16'h3CA5,1,0,0));
    tbl.push_back(mk(1,0,0,8'h00, 0,16'h3CA5,1,0,0));
    // 2: junk while hunting, then a frame
    tbl.push_back(mk(0,0,0,8'h00, 0,16'h0000,0,0,0));
    tbl.push_back(mk(1,1,0,8'h11, 0,16'h0000,0,0,0));
    tbl.push_back(mk(1,1,0,8'h22, 0,16'h0000,0,0,0));
    tbl.push_back(mk(1,1,1,8'h01, 0,16'h0000,1,1,0));
    tbl.push_back(mk(1,1,0,8'h02, 1,16'h0201,1,0,0));
    tbl.push_back(mk(1,0,0,8'h00, 0,16'h0201,1,0,0));
    // 3: early SOF drops the partial frame
    tbl.push_back(mk(1,1,1,8'h10, 0,16'h0201,1,1,0));
    tbl.push_back(mk(1,1,1,8'h20, 0,16'h0201,1,1,1));
    tbl.push_back(mk(1,1,0,8'h30, 1,16'h3020,1,0,0));
    // 4: gaps inside a frame
    tbl.push_back(mk(1,1,1,8'h55, 0,16'h3020,1,1,0));
    tbl.push_back(mk(1,0,0,8'h00, 0,16'h3020,1,1,0));
    tbl.push_back(mk(1,0,1,8'hFF, 0,16'h3020,1,1,0));
    tbl.push_back(mk(1,1,0,8'hAA, 1,16'hAA55,1,0,0));
    // 5: reset mid-frame wins over a valid SOF beat
    tbl.push_back(mk(1,1,1,8'h77, 0,16'hAA55,1,1,0));
    tbl.push_back(mk(0,1,1,8'h66, 0,16'h0000,0,0,0));
    tbl.push_back(mk(1,1,0,8'h99, 0,16'h0000,0,0,0));
    tbl.push_back(mk(1,1,1,8'h12, 0,16'h0000,1,1,0));
    tbl.push_back(mk(1,1,0,8'h34, 1,16'h3412,1,0,0));
    // missing SOF in RUN: lose lock, frame output held
    tbl.push_back(mk(1,1,0,8'hEE, 0,16'h3412,0,0,1));
    tbl.push_back(mk(1,0,0,8'h00, 0,16'h3412,0,0,0));

    foreach (tbl[i]) begin
      rst2 = tbl[i].rst_n; v2 = tbl[i].v; sof2 = tbl[i].sof; d2 = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), 32'(ov2), 32'(tbl[i].ov));
      chk($sformatf("vec%0d out_data", i),  32'(od2), 32'(tbl[i].od));
      chk($sformatf("vec%0d locked", i),    32'(lk2), 32'(tbl[i].lk));
      chk($sformatf("vec%0d slot_idx", i),  32'(si2), 32'(tbl[i].si));
      chk($sformatf("vec%0d sync_err", i),  32'(er2), 32'(tbl[i].er));
    end
    v2 = 0;

    // 6: 3x1 back-to-back frames at full rate
    rst3 = 0; @(posedge clk); #1;
    chk("bb reset slot_idx", 32'(si3), 32'd0);
    rst3 = 1;
    for (int f = 0; f < 4; f++) begin
      for (int s = 0; s < 3; s++) begin
        v3 = 1; sof3 = (s == 0); d3 = 1'($urandom_range(0, 1));
        fr[s] = d3[0];
        @(posedge clk); #1;
        chk($sformatf("bb f%0d s%0d slot_idx", f, s), 32'(si3), 32'((s + 1) % 3));
        chk($sformatf("bb f%0d s%0d out_valid", f, s), 32'(ov3), 32'(s == 2));
        chk($sformatf("bb f%0d s%0d sync_err", f, s), 32'(er3), 32'd0);
        if (s == 2)
          chk($sformatf("bb f%0d out_data", f), 32'(od3), 32'({fr[2], fr[1], fr[0]}));
      end
    end
    v3 = 0;

    // random traffic on both instances against the model
    for (int i = 0; i < 3000; i++) begin
      rst2 = !(i == 0 || $urandom_range(0, 63) == 0);
      v2   = ($urandom_range(0, 3) != 0);
      sof2 = ($urandom_range(0, 9) < 3);
      d2   = 8'($urandom);
      rst3 = !(i == 0 || $urandom_range(0, 63) == 0);
      v3   = ($urandom_range(0, 3) != 0);
      sof3 = ($urandom_range(0, 9) < 3);
      d3   = 1'($urandom);
      m2 = mstep(m2, 2, !rst2, v2, sof2, int'(d2));
      m3 = mstep(m3, 3, !rst3, v3, sof3, int'(d3));
      @(posedge clk); #1;
      chk($sformatf("rnd%0d n2 out_valid", i), 32'(ov2), 32'(m2.ov));
      chk($sformatf("rnd%0d n2 out_data", i),  32'(od2), {16'h0, m2.out[1][7:0], m2.out[0][7:0]});
      chk($sformatf("rnd%0d n2 locked", i),    32'(lk2), 32'(m2.run));
      chk($sformatf("rnd%0d n2 slot_idx", i),  32'(si2), 32'(m2.pos));
      chk($sformatf("rnd%0d n2 sync_err", i),  32'(er2), 32'(m2.err));
      chk($sformatf("rnd%0d n3 out_valid", i), 32'(ov3), 32'(m3.ov));
      chk($sformatf("rnd%0d n3 out_data", i),  32'(od3), {29'h0, m3.out[2][0], m3.out[1][0], m3.out[0][0]});
      chk($sformatf("rnd%0d n3 locked", i),    32'(lk3), 32'(m3.run));
      chk($sformatf("rnd%0d n3 slot_idx", i),  32'(si3), 32'(m3.pos));
      chk($sformatf("rnd%0d n3 sync_err", i),  32'(er3), 32'(m3.err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
